// File: rtl/prog_run_ctrl_pkg.sv
// Shared types and defaults for the batch run sequencer.
//   run_state_t         : sequencer states
//   DEF_*               : default geometry of the load image and the dump window
//   DONE_IGNORE_CYCLES  : leading RUN cycles in which core_done is not trusted
//                         (the core is still leaving reset)
package prog_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DUMP = 2'd3
  } run_state_t;

  localparam int DEF_AW        = 8;
  localparam int DEF_LOAD_BASE = 0;
  localparam int DEF_LOAD_LEN  = 64;
  localparam int DEF_DUMP_BASE = 64;
  localparam int DEF_DUMP_LEN  = 32;
  localparam int DEF_CW        = 16;

  localparam int DONE_IGNORE_CYCLES = 1;

endpackage

// File: rtl/dmem_port_mux.sv
// Data-memory port select between the run sequencer and the core.
// Lives next to the data memory, outside the sequencer.
//   dm_sel               : 1 = controller owns the port, 0 = core owns it
//   ctrl_wr_en/addr/data : controller side
//   core_wr_en/addr/data : core side
//   mem_wr_en/addr/data  : to the data memory
module dmem_port_mux
  import prog_run_ctrl_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          dm_sel,
  input  logic          ctrl_wr_en,
  input  logic [AW-1:0] ctrl_addr,
  input  logic [7:0]    ctrl_wr_data,
  input  logic          core_wr_en,
  input  logic [AW-1:0] core_addr,
  input  logic [7:0]    core_wr_data,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wr_data
);

  assign mem_wr_en   = dm_sel ? ctrl_wr_en   : core_wr_en;
  assign mem_addr    = dm_sel ? ctrl_addr    : core_addr;
  assign mem_wr_data = dm_sel ? ctrl_wr_data : core_wr_data;

endmodule

// File: rtl/prog_run_ctrl.sv
// Batch run sequencer: loads an input image into data memory from a host
// byte stream, runs the core until done (or cycle-count timeout), then
// streams a result window of data memory back to the host.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start / busy          : sequence kick (IDLE only) / not-idle status
//   in_valid/ready/data   : host load stream
//   out_valid/ready/data  : host dump stream
//   core_reset, core_done : core hold and halt flag
//   dm_sel, dm_wr_en, dm_addr, dm_wr_data, dm_rd_data : data-memory port
//   run_cycles, timeout   : result of the last RUN (held until next start)
//   finished              : one-cycle pulse when the dump completes
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// LOAD  | host bytes written to LOAD_BASE+idx, core held in reset
// RUN   | core released, counting cycles until done or timeout
// DUMP  | DUMP_BASE+idx streamed to host, core frozen in reset
module prog_run_ctrl
  import prog_run_ctrl_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int LOAD_BASE = DEF_LOAD_BASE,
  parameter int LOAD_LEN  = DEF_LOAD_LEN,
  parameter int DUMP_BASE = DEF_DUMP_BASE,
  parameter int DUMP_LEN  = DEF_DUMP_LEN,
  parameter int CW        = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          core_reset,
  input  logic          core_done,
  output logic          dm_sel,
  output logic          dm_wr_en,
  output logic [AW-1:0] dm_addr,
  output logic [7:0]    dm_wr_data,
  input  logic [7:0]    dm_rd_data,
  output logic [CW-1:0] run_cycles,
  output logic          timeout,
  output logic          finished
);

  localparam int IW = AW + 1;
  localparam logic [IW-1:0] LOAD_LAST   = IW'(LOAD_LEN - 1);
  localparam logic [IW-1:0] DUMP_LAST   = IW'(DUMP_LEN - 1);
  localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
  localparam logic [AW-1:0] DUMP_BASE_A = AW'(DUMP_BASE);
  localparam logic [CW-1:0] RC_MAX      = '1;
  localparam logic [CW-1:0] RC_IGNORE   = CW'(DONE_IGNORE_CYCLES);

  run_state_t    state, state_next;
  logic [IW-1:0] idx, idx_next;
  logic [CW-1:0] rc_next, rc_inc;
  logic          to_next, fin_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      run_cycles <= '0;
      timeout    <= 1'b0;
      finished   <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      run_cycles <= rc_next;
      timeout    <= to_next;
      finished   <= fin_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    rc_next    = run_cycles;
    to_next    = timeout;
    fin_next   = 1'b0;
    rc_inc     = (run_cycles == RC_MAX) ? run_cycles : run_cycles + 1'b1;

    busy       = (state != IDLE);
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    core_reset = 1'b1;
    dm_sel     = 1'b0;
    dm_wr_en   = 1'b0;
    dm_addr    = '0;
    dm_wr_data = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          idx_next   = '0;
          rc_next    = '0;
          to_next    = 1'b0;
        end
      end
      LOAD: begin
        dm_sel     = 1'b1;
        in_ready   = 1'b1;
        dm_addr    = LOAD_BASE_A + idx[AW-1:0];
        dm_wr_data = in_data;
        dm_wr_en   = in_valid;
        if (in_valid) begin
          if (idx == LOAD_LAST) begin
            state_next = RUN;
            idx_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      RUN: begin
        core_reset = 1'b0;
        rc_next    = rc_inc;
        // run_cycles still holds the count of completed RUN cycles, so it
        // doubles as the "core has left reset" qualifier for core_done.
        // Done is checked first so it wins over a coincident timeout.
        if (core_done && (run_cycles >= RC_IGNORE)) begin
          state_next = DUMP;
        end else if (rc_inc == RC_MAX) begin
          to_next    = 1'b1;
          state_next = DUMP;
        end
      end
      DUMP: begin
        dm_sel    = 1'b1;
        out_valid = 1'b1;
        dm_addr   = DUMP_BASE_A + idx[AW-1:0];
        out_data  = dm_rd_data;
        if (out_ready) begin
          if (idx == DUMP_LAST) begin
            state_next = IDLE;
            idx_next   = '0;
            fin_next   = 1'b1;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
